// File: rtl/frontend_pingpong_ctrl.sv
// frontend_pingpong_ctrl: loads AXI-Stream frames into one half of a two-bank
// BRAM while the decompression engine works on the other half. Byte length is
// accumulated from tkeep and handed to the engine along with a start pulse.
// Optional build macro FRONTEND_PERF_CNT_EN adds frames_done/frames_dropped counters.
module frontend_pingpong_ctrl #(
    parameter int DATA_W     = 256,
    parameter int KEEP_W     = 32,
    parameter int DEPTH_LOG2 = 6,
    parameter int LEN_W      = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic [KEEP_W-1:0]     s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  bram_we,
    output logic [DEPTH_LOG2:0]   bram_addr,
    output logic [DATA_W-1:0]     bram_din,
    output logic                  start,
    output logic                  start_bank,
    output logic [LEN_W-1:0]      length,
    input  logic                  finish,
    output logic                  frame_err
`ifdef FRONTEND_PERF_CNT_EN
    ,
    output logic [31:0]           frames_done,
    output logic [15:0]           frames_dropped
`endif
);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_BUSY    = 2'd3
    } bank_st_e;

    typedef enum logic {
        ENG_IDLE = 1'b0,
        ENG_RUN  = 1'b1
    } eng_st_e;

    // Number of enabled bytes in one beat.
    function automatic logic [LEN_W-1:0] popcount_keep(input logic [KEEP_W-1:0] keep);
        logic [LEN_W-1:0] cnt;
        cnt = {LEN_W{1'b0}};
        for (int i = 0; i < KEEP_W; i++) begin
            cnt = cnt + {{(LEN_W-1){1'b0}}, keep[i]};
        end
        return cnt;
    endfunction

    bank_st_e               bank_st_q [2];
    bank_st_e               bank_st_d [2];
    logic [LEN_W-1:0]       bank_len_q [2];
    logic [LEN_W-1:0]       bank_len_d [2];
    logic                   fill_bank_q, fill_bank_d;
    logic                   eng_bank_q, eng_bank_d;
    logic [DEPTH_LOG2-1:0]  beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0]       len_acc_q, len_acc_d;
    logic                   drop_q, drop_d;
    eng_st_e                eng_st_q, eng_st_d;
    logic                   start_q, start_d;
    logic                   start_bank_q, start_bank_d;
    logic [LEN_W-1:0]       length_q, length_d;
    logic                   frame_err_q, frame_err_d;

    logic                   fill_ready_s;
    logic                   accept_s;
    logic                   write_s;
    logic [LEN_W-1:0]       beat_len_s;

    // Stream handshake and BRAM write port, derived from registered state only.
    // Ready is held low while reset is asserted so no beat is taken during reset.
    always_comb begin
        fill_ready_s  = drop_q
                      | (bank_st_q[fill_bank_q] == BANK_EMPTY)
                      | (bank_st_q[fill_bank_q] == BANK_FILLING);
        s_axis_tready = aresetn & fill_ready_s;
        accept_s      = s_axis_tvalid & s_axis_tready;
        write_s       = accept_s & ~drop_q;
        beat_len_s    = popcount_keep(s_axis_tkeep);
        bram_we       = write_s;
        if (write_s) begin
            bram_addr = {fill_bank_q, beat_cnt_q};
            bram_din  = s_axis_tdata;
        end else begin
            bram_addr = {(DEPTH_LOG2+1){1'b0}};
            bram_din  = {DATA_W{1'b0}};
        end
    end

    // Next-state logic: fill side touches only bank[fill_bank] (EMPTY/FILLING),
    // engine side touches only bank[eng_bank] (FULL/BUSY), so they never collide.
    always_comb begin
        bank_st_d    = bank_st_q;
        bank_len_d   = bank_len_q;
        fill_bank_d  = fill_bank_q;
        eng_bank_d   = eng_bank_q;
        beat_cnt_d   = beat_cnt_q;
        len_acc_d    = len_acc_q;
        drop_d       = drop_q;
        eng_st_d     = eng_st_q;
        start_d      = 1'b0;
        start_bank_d = start_bank_q;
        length_d     = length_q;
        frame_err_d  = 1'b0;

        if (accept_s) begin
            if (drop_q) begin
                if (s_axis_tlast) begin
                    // Oversize frame ends: release the bank for a fresh frame.
                    drop_d                   = 1'b0;
                    frame_err_d              = 1'b1;
                    bank_st_d[fill_bank_q]   = BANK_EMPTY;
                    beat_cnt_d               = {DEPTH_LOG2{1'b0}};
                    len_acc_d                = {LEN_W{1'b0}};
                end else begin
                    drop_d = 1'b1;
                end
            end else if (s_axis_tlast) begin
                bank_len_d[fill_bank_q] = len_acc_q + beat_len_s;
                bank_st_d[fill_bank_q]  = BANK_FULL;
                fill_bank_d             = ~fill_bank_q;
                beat_cnt_d              = {DEPTH_LOG2{1'b0}};
                len_acc_d               = {LEN_W{1'b0}};
            end else if (beat_cnt_q == {DEPTH_LOG2{1'b1}}) begin
                // Last slot written without tlast: discard the rest of the frame.
                bank_st_d[fill_bank_q] = BANK_FILLING;
                drop_d                 = 1'b1;
                beat_cnt_d             = {DEPTH_LOG2{1'b0}};
                len_acc_d              = {LEN_W{1'b0}};
            end else begin
                bank_st_d[fill_bank_q] = BANK_FILLING;
                beat_cnt_d             = beat_cnt_q + DEPTH_LOG2'(1);
                len_acc_d              = len_acc_q + beat_len_s;
            end
        end else begin
            drop_d = drop_q;
        end

        case (eng_st_q)
            ENG_IDLE: begin
                if (bank_st_q[eng_bank_q] == BANK_FULL) begin
                    start_d               = 1'b1;
                    start_bank_d          = eng_bank_q;
                    length_d              = bank_len_q[eng_bank_q];
                    bank_st_d[eng_bank_q] = BANK_BUSY;
                    eng_st_d              = ENG_RUN;
                end else begin
                    eng_st_d = ENG_IDLE;
                end
            end
            ENG_RUN: begin
                if (finish) begin
                    bank_st_d[eng_bank_q] = BANK_EMPTY;
                    eng_bank_d            = ~eng_bank_q;
                    eng_st_d              = ENG_IDLE;
                end else begin
                    eng_st_d = ENG_RUN;
                end
            end
            default: begin
                eng_st_d = ENG_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            bank_st_q[0]  <= BANK_EMPTY;
            bank_st_q[1]  <= BANK_EMPTY;
            bank_len_q[0] <= {LEN_W{1'b0}};
            bank_len_q[1] <= {LEN_W{1'b0}};
            fill_bank_q   <= 1'b0;
            eng_bank_q    <= 1'b0;
            beat_cnt_q    <= {DEPTH_LOG2{1'b0}};
            len_acc_q     <= {LEN_W{1'b0}};
            drop_q        <= 1'b0;
            eng_st_q      <= ENG_IDLE;
            start_q       <= 1'b0;
            start_bank_q  <= 1'b0;
            length_q      <= {LEN_W{1'b0}};
            frame_err_q   <= 1'b0;
        end else begin
            bank_st_q     <= bank_st_d;
            bank_len_q    <= bank_len_d;
            fill_bank_q   <= fill_bank_d;
            eng_bank_q    <= eng_bank_d;
            beat_cnt_q    <= beat_cnt_d;
            len_acc_q     <= len_acc_d;
            drop_q        <= drop_d;
            eng_st_q      <= eng_st_d;
            start_q       <= start_d;
            start_bank_q  <= start_bank_d;
            length_q      <= length_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign start      = start_q;
    assign start_bank = start_bank_q;
    assign length     = length_q;
    assign frame_err  = frame_err_q;

`ifdef FRONTEND_PERF_CNT_EN
    logic [31:0] frames_done_q, frames_done_d;
    logic [15:0] frames_dropped_q, frames_dropped_d;

    // Wrapping event counters: completed engine runs and dropped frames.
    always_comb begin
        if ((eng_st_q == ENG_RUN) && finish) begin
            frames_done_d = frames_done_q + 32'd1;
        end else begin
            frames_done_d = frames_done_q;
        end
        if (frame_err_d) begin
            frames_dropped_d = frames_dropped_q + 16'd1;
        end else begin
            frames_dropped_d = frames_dropped_q;
        end
    end

    // Counter registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            frames_done_q    <= 32'd0;
            frames_dropped_q <= 16'd0;
        end else begin
            frames_done_q    <= frames_done_d;
            frames_dropped_q <= frames_dropped_d;
        end
    end

    assign frames_done    = frames_done_q;
    assign frames_dropped = frames_dropped_q;
`endif

endmodule
